// File: rtl/fwd_hazard_if.sv
// Issue-side bundle for the forwarding/hazard scoreboard.
// The pipeline control drives the master side; the scoreboard is the slave.
interface fwd_hazard_if #(
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(DEPTH+1)
);
  logic                      advance;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_wen;
  logic [REG_AW-1:0]         issue_dst;
  logic [SEL_W-1:0]          issue_lat;
  logic [NUM_RD-1:0]         rd_valid;
  logic [NUM_RD*REG_AW-1:0]  rd_addr;
  logic [NUM_RD*SEL_W-1:0]   fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output advance, flush, issue_valid, issue_wen, issue_dst, issue_lat,
           rd_valid, rd_addr,
    input  fwd_sel, stall, stall_cnt
  );
  modport slave (
    input  advance, flush, issue_valid, issue_wen, issue_dst, issue_lat,
           rd_valid, rd_addr,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// In-flight write tracker: resolves each source operand to a forwarding
// slot or a RAW stall, from a DEPTH-slot shift register of producers.

module fwd_port_resolve #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic                          rd_valid,
  input  logic [REG_AW-1:0]             rd_addr,
  input  logic [DEPTH-1:0]              live,
  input  logic [DEPTH-1:0][REG_AW-1:0]  dst,
  input  logic [DEPTH-1:0][SEL_W-1:0]   lat,
  output logic [SEL_W-1:0]              sel,
  output logic                          req
);
  // Scan oldest to youngest so the youngest match has the last word.
  always_comb begin
    sel = '0;
    req = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (rd_valid && rd_addr != '0 && live[k] && dst[k] == rd_addr) begin
        if (SEL_W'(k+1) >= lat[k]) begin
          sel = SEL_W'(k+1);
          req = 1'b0;
        end else begin
          sel = '0;
          req = 1'b1;
        end
      end
    end
  end
endmodule

module fwd_hazard_scoreboard #(
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  fwd_hazard_if.slave   bus
);
  logic [DEPTH-1:0]              vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0][REG_AW-1:0]  dst_q, dst_d;
  logic [DEPTH-1:0][SEL_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [DEPTH-1:0]              live;
  logic [NUM_RD-1:0][REG_AW-1:0] rd_addr;
  logic [NUM_RD-1:0][SEL_W-1:0]  sel;
  logic [NUM_RD-1:0]             req;
  logic [SEL_W-1:0]              lat_in;
  logic                          stall, accept;

  assign rd_addr = bus.rd_addr;

  // Slot valid already folds in wen; dst==0 is filtered here.
  always_comb begin
    live = '0;
    for (int k = 0; k < DEPTH; k++)
      live[k] = vld_pipe_q[k] && (dst_q[k] != '0);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_port_resolve #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_res (
      .rd_valid (bus.rd_valid[i]),
      .rd_addr  (rd_addr[i]),
      .live     (live),
      .dst      (dst_q),
      .lat      (lat_q),
      .sel      (sel[i]),
      .req      (req[i])
    );
  end

  assign stall         = bus.issue_valid && (|req);
  assign accept        = bus.issue_valid && bus.advance && !stall && !bus.flush;
  assign bus.stall     = stall;
  assign bus.fwd_sel   = sel;
  assign bus.stall_cnt = cnt_q;

  always_comb begin
    lat_in = bus.issue_lat;
    if (bus.issue_lat == '0)                lat_in = SEL_W'(1);
    else if (bus.issue_lat > SEL_W'(DEPTH)) lat_in = SEL_W'(DEPTH);
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    dst_d      = dst_q;
    lat_d      = lat_q;
    if (!bus.advance) begin
      if (bus.flush) vld_pipe_d[0] = 1'b0;
    end else begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        // The squashed slot0 entry would land in slot1 on a flushing shift.
        vld_pipe_d[k] = (bus.flush && k == 1) ? 1'b0 : vld_pipe_q[k-1];
        dst_d[k]      = dst_q[k-1];
        lat_d[k]      = lat_q[k-1];
      end
      vld_pipe_d[0] = accept && bus.issue_wen;
      dst_d[0]      = bus.issue_dst;
      lat_d[0]      = lat_in;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && bus.advance && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      dst_q      <= '0;
      lat_q      <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dst_q      <= dst_d;
      lat_q      <= lat_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed scoreboard bench: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fwd_hazard_scoreboard;
  localparam int NUM_RD = 2, DEPTH = 3, REG_AW = 5, CNT_W = 16, SEL_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .REG_AW(REG_AW),
                  .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  fwd_hazard_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .REG_AW(REG_AW),
                          .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "sel0",  16'(bus.fwd_sel[1:0]), 16'(e.s0));
      chk(e.name, "sel1",  16'(bus.fwd_sel[3:2]), 16'(e.s1));
      chk(e.name, "stall", 16'(bus.stall), 16'(e.st));
      chk(e.name, "cnt",   bus.stall_cnt, e.cnt);
    end
  end

  task automatic drv(input string nm, input logic adv, input logic fl, input logic iv,
                     input logic wen, input logic [4:0] dst, input logic [1:0] lat,
                     input logic [1:0] rv, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [1:0] e0, input logic [1:0] e1, input logic est,
                     input logic [15:0] ecnt);
    exp_t x;
    @(posedge clk); #1;
    bus.advance     = adv;
    bus.flush       = fl;
    bus.issue_valid = iv;
    bus.issue_wen   = wen;
    bus.issue_dst   = dst;
    bus.issue_lat   = lat;
    bus.rd_valid    = rv;
    bus.rd_addr     = {a1, a0};
    x.name = nm; x.s0 = e0; x.s1 = e1; x.st = est; x.cnt = ecnt;
    q.push_back(x);
  endtask

  initial begin
    exp_t r;
    bus.advance = 1'b0; bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_wen = 1'b0;
    bus.issue_dst = '0; bus.issue_lat = '0; bus.rd_valid = '0; bus.rd_addr = '0;
    #1;
    r.name = "reset"; r.s0 = 0; r.s1 = 0; r.st = 0; r.cnt = 0;
    q.push_back(r);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    //   name              adv fl iv wen dst lat rv     a0  a1  e0 e1 st cnt
    drv("idle",            1, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 0, 0, 0);
    drv("alu_issue",       1, 0, 1, 1,  5, 1, 2'b00,  0,  0, 0, 0, 0, 0);
    drv("alu_fwd",         1, 0, 1, 0,  0, 0, 2'b01,  5,  0, 1, 0, 0, 0);
    drv("ld_issue",        1, 0, 1, 1,  8, 2, 2'b00,  0,  0, 0, 0, 0, 0);
    drv("ld_use_stall",    1, 0, 1, 0,  0, 0, 2'b10,  0,  8, 0, 0, 1, 0);
    drv("ld_use_fwd",      1, 0, 1, 0,  0, 0, 2'b10,  0,  8, 0, 2, 0, 1);
    drv("pri_a",           1, 0, 1, 1,  3, 1, 2'b00,  0,  0, 0, 0, 0, 1);
    drv("pri_zero",        1, 0, 1, 1,  0, 1, 2'b00,  0,  0, 0, 0, 0, 1);
    drv("pri_b",           1, 0, 1, 1,  3, 1, 2'b00,  0,  0, 0, 0, 0, 1);
    drv("pri_young",       1, 0, 1, 0,  0, 0, 2'b11,  3,  0, 1, 0, 0, 1);
    drv("hold_a",          0, 0, 1, 0,  0, 0, 2'b01,  3,  0, 2, 0, 0, 1);
    drv("hold_b",          0, 0, 1, 0,  0, 0, 2'b01,  3,  0, 2, 0, 0, 1);
    drv("hold_rel",        1, 0, 1, 0,  0, 0, 2'b01,  3,  0, 2, 0, 0, 1);
    drv("fl_issue",        1, 0, 1, 1,  9, 1, 2'b00,  0,  0, 0, 0, 0, 1);
    drv("fl_squash",       1, 1, 1, 1, 10, 1, 2'b01,  9,  0, 1, 0, 0, 1);
    drv("fl_after",        1, 0, 1, 0,  0, 0, 2'b11,  9, 10, 0, 0, 0, 1);
    drv("hfl_issue",       1, 0, 1, 1, 11, 1, 2'b00,  0,  0, 0, 0, 0, 1);
    drv("hfl_squash",      0, 1, 1, 0,  0, 0, 2'b01, 11,  0, 1, 0, 0, 1);
    drv("hfl_after",       1, 0, 1, 0,  0, 0, 2'b01, 11,  0, 0, 0, 0, 1);
    drv("ret_issue",       1, 0, 1, 1,  7, 3, 2'b00,  0,  0, 0, 0, 0, 1);
    drv("ret_hold_stall",  0, 0, 1, 0,  0, 0, 2'b01,  7,  0, 0, 0, 1, 1);
    drv("ret_s0",          1, 0, 1, 0,  0, 0, 2'b01,  7,  0, 0, 0, 1, 1);
    drv("ret_s1",          1, 0, 1, 0,  0, 0, 2'b01,  7,  0, 0, 0, 1, 2);
    drv("ret_s2",          1, 0, 1, 0,  0, 0, 2'b01,  7,  0, 3, 0, 0, 3);
    drv("ret_gone",        1, 0, 1, 1, 12, 0, 2'b01,  7,  0, 0, 0, 0, 3);
    drv("lat0_fwd",        1, 0, 1, 0,  0, 0, 2'b11, 12, 12, 1, 1, 0, 3);
    drv("gate_issue",      1, 0, 1, 1, 13, 2, 2'b00,  0,  0, 0, 0, 0, 3);
    drv("gate_novalid",    1, 0, 0, 0,  0, 0, 2'b01, 13,  0, 0, 0, 0, 3);
    drv("full_a",          1, 0, 1, 1, 14, 3, 2'b00,  0,  0, 0, 0, 0, 3);
    drv("full_stall",      1, 0, 1, 0,  0, 0, 2'b01, 14,  0, 0, 0, 1, 3);
    drv("full_b",          1, 0, 1, 1, 15, 3, 2'b00,  0,  0, 0, 0, 0, 4);
    drv("full_c",          1, 0, 1, 1, 16, 3, 2'b00,  0,  0, 0, 0, 0, 4);
    drv("full_d",          1, 0, 1, 1, 17, 1, 2'b00,  0,  0, 0, 0, 0, 4);
    drv("full_chk",        0, 0, 1, 0,  0, 0, 2'b11, 15, 16, 3, 0, 1, 4);

    // Asynchronous reset between edges, inputs still requesting a stall.
    @(posedge clk); #1;
    rst_n = 1'b0;
    r.name = "rst_midop"; r.s0 = 0; r.s1 = 0; r.st = 0; r.cnt = 0;
    q.push_back(r);
    @(posedge clk); #1 rst_n = 1'b1;
    drv("post_rst",        1, 0, 1, 0,  0, 0, 2'b11, 15, 16, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain queue_left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
